// File: rtl/fetch_request_unit.sv
// PC owner and fetch/data request sequencer for the single-cycle MIPS core.
// Holds LW/SW requests until the data cache acknowledges them.
package cpu_types_pkg;
  typedef enum logic [2:0] {
    NEXT         = 3'd0,
    BRANCH       = 3'd1,
    JUMP         = 3'd2,
    JUMPREGISTER = 3'd3,
    PC_HALT      = 3'd4
  } pc_select_t;
endpackage

module fetch_request_unit
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic [2:0]  pc_select,
  input  logic [31:0] jump_data,
  input  logic [31:0] immediate,
  input  logic        cu_dREN,
  input  logic        cu_dWEN,
  output logic [31:0] imemaddr,
  output logic        imemREN,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] pc_plus4,
  output logic        retire,
  output logic        halt
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    MEM    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] next_pc;
  logic        mem_op;
  logic        fetch_ok;
  logic        mem_done;

  assign pc_plus4 = imemaddr + 32'd4;
  assign mem_op   = cu_dREN | cu_dWEN;
  assign fetch_ok = (state == FETCH) & ihit;
  assign mem_done = (state == MEM) & dhit;
  assign imemREN  = (state == FETCH);
  assign retire   = (fetch_ok & ~mem_op) | mem_done;

  // Undefined selector encodings fall back to sequential fetch.
  always_comb begin
    next_pc = pc_plus4;
    case (pc_select)
      BRANCH:
        next_pc = pc_plus4 + (immediate << 2);
      JUMP:
        next_pc = {pc_plus4[31:28], jump_data[25:0], 2'b00};
      JUMPREGISTER:
        next_pc = {jump_data[31:2], 2'b00};
      PC_HALT:
        next_pc = imemaddr;
      default:
        next_pc = pc_plus4;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= FETCH;
      imemaddr <= PC_INIT;
      dmemREN  <= 1'b0;
      dmemWEN  <= 1'b0;
      halt     <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (ihit) begin
            if (mem_op) begin
              state   <= MEM;
              dmemREN <= cu_dREN;
              dmemWEN <= cu_dWEN;
            end else if (pc_select == PC_HALT) begin
              state <= HALTED;
              halt  <= 1'b1;
            end else begin
              imemaddr <= next_pc;
            end
          end
        end
        MEM: begin
          if (dhit) begin
            state    <= FETCH;
            imemaddr <= pc_plus4;
            dmemREN  <= 1'b0;
            dmemWEN  <= 1'b0;
          end
        end
        HALTED: begin
          halt    <= 1'b1;
          dmemREN <= 1'b0;
          dmemWEN <= 1'b0;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule
